// File: rtl/regfile_2w2r_sb.sv
// Register file with two write ports and two read ports.
// Port A carries the ALU writeback and port B carries the load return.
// Reads are combinational, and same-cycle writes can optionally be forwarded to them.
// A load scoreboard marks each register that has a load outstanding, so decode can stall.
module regfile_2w2r_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we_a,
  input  logic [AW-1:0]   rd_a,
  input  logic [XLEN-1:0] wd_a,
  input  logic            we_b,
  input  logic [AW-1:0]   rd_b,
  input  logic [XLEN-1:0] wd_b,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  input  logic            ld_issue,
  input  logic [AW-1:0]   ld_rd,
  output logic            busy1,
  output logic            busy2,
  output logic [AW:0]     pending_count
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;

  logic setHit;
  logic clrHit;
  logic incHit;

  // Store writebacks; the younger ALU write wins over a load return to the same index
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      regs[0] <= '0;
      for (int i = 1; i < NREGS; i++) begin
        if (we_a && (rd_a == AW'(i))) begin
          regs[i] <= wd_a;
        end else if (we_b && (rd_b == AW'(i))) begin
          regs[i] <= wd_b;
        end
      end
    end
  end

  // Read port 1: stored value, optionally overridden by a same-cycle write (port A first)
  always_comb begin
    readData1 = regs[rs1];
    if (BYPASS != 0) begin
      if (we_b && (rd_b == rs1)) begin
        readData1 = wd_b;
      end
      if (we_a && (rd_a == rs1)) begin
        readData1 = wd_a;
      end
    end
    if (rs1 == '0) begin
      readData1 = '0;
    end
  end

  // Read port 2: same forwarding rules as read port 1
  always_comb begin
    readData2 = regs[rs2];
    if (BYPASS != 0) begin
      if (we_b && (rd_b == rs2)) begin
        readData2 = wd_b;
      end
      if (we_a && (rd_a == rs2)) begin
        readData2 = wd_a;
      end
    end
    if (rs2 == '0) begin
      readData2 = '0;
    end
  end

  // Scoreboard events: a set wins over a clear that targets the same index in the same cycle
  always_comb begin
    setHit = ld_issue && (ld_rd != '0);
    clrHit = we_b && (rd_b != '0) && busy[rd_b] && !(setHit && (ld_rd == rd_b));
    incHit = setHit && !busy[ld_rd];
  end

  // Track outstanding loads and keep a running count of busy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      busy          <= '0;
      pending_count <= '0;
    end else begin
      if (clrHit) begin
        busy[rd_b] <= 1'b0;
      end
      if (setHit) begin
        busy[ld_rd] <= 1'b1;
      end
      case ({incHit, clrHit})
        2'b10:   pending_count <= pending_count + (AW+1)'(1);
        2'b01:   pending_count <= pending_count - (AW+1)'(1);
        default: pending_count <= pending_count;
      endcase
    end
  end

  assign busy1 = busy[rs1];
  assign busy2 = busy[rs2];

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Testbench for regfile_2w2r_sb.
// Instantiates the register file twice, once with bypass and once without, and drives both with the same inputs.
// Expected values are queued when a stimulus is driven and are checked against the DUT outputs later.
module tb_regfile_2w2r_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            we_a, we_b, ld_issue;
  logic [AW-1:0]   rd_a, rd_b, rs1, rs2, ld_rd;
  logic [XLEN-1:0] wd_a, wd_b;
  logic [XLEN-1:0] readData1, readData2, rd1Nb, rd2Nb;
  logic            busy1, busy2, busy1Nb, busy2Nb;
  logic [AW:0]     pending_count, cntNb;

  typedef enum int {S_RD1, S_RD2, S_B1, S_B2, S_CNT, S_RD1NB, S_RD2NB, S_CNTNB} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  regfile_2w2r_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut (
    .clk(clk), .reset(reset),
    .we_a(we_a), .rd_a(rd_a), .wd_a(wd_a),
    .we_b(we_b), .rd_b(rd_b), .wd_b(wd_b),
    .rs1(rs1), .rs2(rs2), .readData1(readData1), .readData2(readData2),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
    .busy1(busy1), .busy2(busy2), .pending_count(pending_count)
  );

  regfile_2w2r_sb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dutNb (
    .clk(clk), .reset(reset),
    .we_a(we_a), .rd_a(rd_a), .wd_a(wd_a),
    .we_b(we_b), .rd_b(rd_b), .wd_b(wd_b),
    .rs1(rs1), .rs2(rs2), .readData1(rd1Nb), .readData2(rd2Nb),
    .ld_issue(ld_issue), .ld_rd(ld_rd),
    .busy1(busy1Nb), .busy2(busy2Nb), .pending_count(cntNb)
  );

  // Select the DUT output that an expectation refers to
  function automatic logic [31:0] observe(sig_e s);
    case (s)
      S_RD1:   return readData1;
      S_RD2:   return readData2;
      S_B1:    return 32'(busy1);
      S_B2:    return 32'(busy2);
      S_CNT:   return 32'(pending_count);
      S_RD1NB: return rd1Nb;
      S_RD2NB: return rd2Nb;
      S_CNTNB: return 32'(cntNb);
      default: return 'x;
    endcase
  endfunction

  task automatic push(input string tag, input sig_e s, input logic [31:0] v);
    exp_t x;
    x.tag = tag;
    x.sig = s;
    x.val = v;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset    = 1'b0;
    we_a     = 1'b0;
    we_b     = 1'b0;
    ld_issue = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    rs1 = '0; rs2 = '0; rd_a = '0; rd_b = '0; ld_rd = '0; wd_a = '0; wd_b = '0;
    idle();
    reset = 1'b1; we_a = 1'b1; rd_a = 5'd5; wd_a = 32'hFFFF_FFFF; ld_issue = 1'b1; ld_rd = 5'd3;
    step();
    step();
    idle();
    rs1 = 5'd5; rs2 = 5'd31;
    #1;
    push("reset_rd1", S_RD1, 32'h0);
    push("reset_rd2", S_RD2, 32'h0);
    push("reset_busy1", S_B1, 32'h0);
    push("reset_busy2", S_B2, 32'h0);
    push("reset_count", S_CNT, 32'h0);
    push("reset_count_nb", S_CNTNB, 32'h0);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [31:0] obs;
    we_a = 1'b1; rd_a = 5'd7; wd_a = 32'hDEAD_BEEF;
    we_b = 1'b1; rd_b = 5'd10; wd_b = 32'h0000_1234;
    rs1 = 5'd7; rs2 = 5'd10;
    #1;
    push("bypass_a_rd1", S_RD1, 32'hDEAD_BEEF);
    push("bypass_b_rd2", S_RD2, 32'h0000_1234);
    push("nobypass_rd1_same_cycle", S_RD1NB, 32'h0);
    push("nobypass_rd2_same_cycle", S_RD2NB, 32'h0);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    step();
    idle();
    #1;
    push("stored_rd1", S_RD1, 32'hDEAD_BEEF);
    push("nobypass_rd1_next_cycle", S_RD1NB, 32'hDEAD_BEEF);
    push("nobypass_rd2_next_cycle", S_RD2NB, 32'h0000_1234);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    we_a = 1'b1; rd_a = 5'd0; wd_a = 32'h5555_5555; rs1 = 5'd0;
    #1;
    push("bypass_x0_rd1", S_RD1, 32'h0);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    step();
    idle();
  endtask

  task automatic test_collision();
    exp_t e;
    logic [31:0] obs;
    we_a = 1'b1; rd_a = 5'd3; wd_a = 32'h11;
    we_b = 1'b1; rd_b = 5'd3; wd_b = 32'h22;
    rs1 = 5'd3;
    #1;
    push("collision_bypass_a_wins", S_RD1, 32'h11);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    step();
    idle();
    #1;
    push("collision_stored_a_wins", S_RD1, 32'h11);
    push("collision_stored_nb", S_RD1NB, 32'h11);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    we_a = 1'b1; rd_a = 5'd0; wd_a = 32'h55;
    we_b = 1'b1; rd_b = 5'd0; wd_b = 32'h55;
    rs1 = 5'd0;
    #1;
    push("x0_write_bypass", S_RD1, 32'h0);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    step();
    idle();
    #1;
    push("x0_write_dropped", S_RD1, 32'h0);
    push("x0_write_dropped_nb", S_RD1NB, 32'h0);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    logic [31:0] obs;
    ld_issue = 1'b1; ld_rd = 5'd9; rs1 = 5'd9;
    #1;
    push("busy_not_yet_visible", S_B1, 32'h0);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    step();
    idle();
    #1;
    push("busy_after_issue", S_B1, 32'h1);
    push("count_after_issue", S_CNT, 32'h1);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    we_b = 1'b1; rd_b = 5'd9; wd_b = 32'hAB;
    #1;
    push("load_return_bypass", S_RD1, 32'hAB);
    push("load_return_nb", S_RD1NB, 32'h0);
    push("busy_not_bypassed", S_B1, 32'h1);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    step();
    idle();
    #1;
    push("busy_cleared", S_B1, 32'h0);
    push("count_cleared", S_CNT, 32'h0);
    push("load_data_stored", S_RD1, 32'hAB);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    ld_issue = 1'b1; ld_rd = 5'd0; rs1 = 5'd0;
    step();
    idle();
    #1;
    push("issue_x0_count", S_CNT, 32'h0);
    push("issue_x0_busy", S_B1, 32'h0);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    we_b = 1'b1; rd_b = 5'd12; wd_b = 32'h77; rs2 = 5'd12;
    step();
    idle();
    #1;
    push("non_busy_we_b_count", S_CNT, 32'h0);
    push("non_busy_we_b_data", S_RD2, 32'h77);
    push("non_busy_we_b_busy", S_B2, 32'h0);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
  endtask

  task automatic test_race();
    exp_t e;
    logic [31:0] obs;
    ld_issue = 1'b1; ld_rd = 5'd4; rs2 = 5'd4;
    step();
    idle();
    #1;
    push("race_setup_count", S_CNT, 32'h1);
    push("race_setup_busy", S_B2, 32'h1);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    ld_issue = 1'b1; ld_rd = 5'd4; we_b = 1'b1; rd_b = 5'd4; wd_b = 32'h44;
    step();
    idle();
    #1;
    push("race_set_wins_busy", S_B2, 32'h1);
    push("race_count_unchanged", S_CNT, 32'h1);
    push("race_data_stored", S_RD2, 32'h44);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    ld_issue = 1'b1; ld_rd = 5'd4;
    step();
    idle();
    #1;
    push("reissue_busy_no_increment", S_CNT, 32'h1);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    ld_issue = 1'b1; ld_rd = 5'd6; we_b = 1'b1; rd_b = 5'd4; wd_b = 32'h45; rs1 = 5'd6;
    step();
    idle();
    #1;
    push("swap_clear_other", S_B2, 32'h0);
    push("swap_set_other", S_B1, 32'h1);
    push("swap_count_net_zero", S_CNT, 32'h1);
    push("swap_data", S_RD2, 32'h45);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    we_b = 1'b1; rd_b = 5'd6; wd_b = 32'h66;
    step();
    idle();
    #1;
    push("drain_count", S_CNT, 32'h0);
    push("drain_busy", S_B1, 32'h0);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [31:0] obs;
    ld_issue = 1'b1; ld_rd = 5'd20; we_a = 1'b1; rd_a = 5'd15; wd_a = 32'hCAFE;
    step();
    idle();
    ld_issue = 1'b1; ld_rd = 5'd21;
    step();
    ld_rd = 5'd22;
    step();
    idle();
    rs1 = 5'd15; rs2 = 5'd20;
    #1;
    push("mid_count_three", S_CNT, 32'h3);
    push("mid_busy", S_B2, 32'h1);
    push("mid_data", S_RD1, 32'hCAFE);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    push("post_reset_rd1", S_RD1, 32'h0);
    push("post_reset_rd1_nb", S_RD1NB, 32'h0);
    push("post_reset_busy", S_B2, 32'h0);
    push("post_reset_count", S_CNT, 32'h0);
    push("post_reset_count_nb", S_CNTNB, 32'h0);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    we_b = 1'b1; rd_b = 5'd20; wd_b = 32'h99;
    step();
    idle();
    #1;
    push("stale_return_no_underflow", S_CNT, 32'h0);
    push("stale_return_data", S_RD2, 32'h99);
    push("stale_return_busy", S_B2, 32'h0);
    while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
      if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [31:0] obs;
    logic [31:0] mregs [NREGS];
    logic [31:0] mbusy;
    logic [31:0] exp1, exp2;
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) mregs[i] = '0;
    mbusy = '0;
    for (int c = 0; c < 300; c++) begin
      we_a = 1'($urandom_range(0, 1)); rd_a = AW'($urandom_range(0, 7)); wd_a = $urandom;
      we_b = 1'($urandom_range(0, 1)); rd_b = AW'($urandom_range(0, 7)); wd_b = $urandom;
      ld_issue = ($urandom_range(0, 2) == 0); ld_rd = AW'($urandom_range(0, 7));
      rs1 = AW'($urandom_range(0, 7)); rs2 = AW'($urandom_range(0, 7));
      #1;
      if (rs1 == 0) exp1 = 0; else if (we_a && rd_a == rs1) exp1 = wd_a;
      else if (we_b && rd_b == rs1) exp1 = wd_b; else exp1 = mregs[rs1];
      if (rs2 == 0) exp2 = 0; else if (we_a && rd_a == rs2) exp2 = wd_a;
      else if (we_b && rd_b == rs2) exp2 = wd_b; else exp2 = mregs[rs2];
      push("rand_rd1", S_RD1, exp1);
      push("rand_rd2", S_RD2, exp2);
      push("rand_rd1_nb", S_RD1NB, (rs1 == 0) ? 32'h0 : mregs[rs1]);
      push("rand_busy1", S_B1, 32'(mbusy[rs1]));
      push("rand_busy2", S_B2, 32'(mbusy[rs2]));
      while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
        if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
      if (we_b && rd_b != 0) begin mregs[rd_b] = wd_b; mbusy[rd_b] = 1'b0; end
      if (we_a && rd_a != 0) mregs[rd_a] = wd_a;
      if (ld_issue && ld_rd != 0) mbusy[ld_rd] = 1'b1;
      step();
      push("rand_count", S_CNT, 32'($countones(mbusy)));
      push("rand_count_nb", S_CNTNB, 32'($countones(mbusy)));
      while (sb.size() > 0) begin e = sb.pop_front(); obs = observe(e.sig); checks++;
        if (obs !== e.val) begin errors++; $display("[TB] FAIL %s: got %h, expected %h", e.tag, obs, e.val); end end
    end
    idle();
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_race();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_2w2r_sb.md
Name: regfile_2w2r_sb

Overview:
- Parametrised successor to the core's single-write register file: two write ports, two read ports, write-to-read bypass, and a load scoreboard.
- Write port A carries the ALU writeback. Write port B carries the late writeback from the load unit.
- The scoreboard tracks registers with an outstanding load, so decode can stall on read-after-write (RAW) hazards.
- Sits between decode (reads, load issue) and the two writeback paths.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be a power of two, ≥ 2.
- AW, $clog2(NREGS), register index width (derived; do not override).
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return the stored value only.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- we_a  in  1  write enable, port A (ALU).
- rd_a  in  AW  destination index, port A.
- wd_a  in  XLEN  write data, port A.
- we_b  in  1  write enable, port B (load return).
- rd_b  in  AW  destination index, port B.
- wd_b  in  XLEN  write data, port B.
- rs1  in  AW  read index 1.
- rs2  in  AW  read index 2.
- readData1  out  XLEN  read data 1.
- readData2  out  XLEN  read data 2.
- ld_issue  in  1  a load targeting ld_rd issues this cycle.
- ld_rd  in  AW  destination of the issuing load.
- busy1  out  1  rs1 has an outstanding load.
- busy2  out  1  rs2 has an outstanding load.
- pending_count  out  AW+1  number of registers currently marked busy.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- While reset is high at a rising edge:
  - all NREGS registers are cleared to 0;
  - all busy bits are cleared;
  - pending_count is set to 0;
  - all write and issue inputs are ignored.
  - Reset asserted mid-load discards the pending state. A port B write in the first cycle after reset is accepted as an ordinary write and does not underflow the count.
- Register 0:
  - hardwired to 0; writes to index 0 are dropped;
  - it is never busy; ld_issue with ld_rd=0 is ignored;
  - readData for index 0 is always 0, bypass included.
- Reads are combinational. readDataN = stored[rsN] unless BYPASS=1 and a same-cycle write matches rsN:
  - a port A match takes precedence over a port B match;
  - a matching write is forwarded only when its we=1 and rd≠0.
- Writes take effect at the rising edge.
  - If we_a and we_b target the same rd in the same cycle, port A data is stored (port A is the younger instruction). Port B data is discarded.
  - Its busy-clear still applies; see the ld_issue rule below.
- Scoreboard: busy[NREGS-1:0]; busyN = busy[rsN], combinational, not bypassed.
  - ld_issue sets busy[ld_rd] at the edge.
  - we_b with a busy rd_b clears busy[rd_b].
  - we_b to a non-busy register writes data only; the count is unchanged.
  - Same-cycle ld_issue and we_b to the same index: set wins; the register stays busy and the count is unchanged.
  - ld_issue to an already-busy register: stays busy, no count increment. Only one outstanding load per register is tracked; issue logic must not overlap loads to the same rd.
  - we_a never touches the scoreboard.
- pending_count:
  - registered; equals the popcount of busy after every edge;
  - updated incrementally by +1, 0 or -1 per cycle;
  - never exceeds NREGS-1 (x0 is excluded) and never wraps.
- Latency: 0 cycles write-to-read with bypass, 1 cycle without. Busy is visible the cycle after ld_issue.
- Initial register contents before the first reset are not specified; the bench must reset first.

Test Plan:
1. Reset then read: assert reset for 1 cycle. Read rs1=5, rs2=31 → readData1=readData2=0, busy1=busy2=0, pending_count=0.
2. Bypass:
   - write we_a=1, rd_a=7, wd_a=0xDEADBEEF with rs1=7 in the same cycle → readData1=0xDEADBEEF combinationally;
   - with BYPASS=0, readData1=0 that cycle and 0xDEADBEEF the next.
3. Dual-write collision: we_a rd_a=3 wd_a=0x11, we_b rd_b=3 wd_b=0x22 in the same cycle → next cycle reads 0x11. Writes of 0x55 to index 0 on both ports → rs1=0 reads 0.
4. Scoreboard:
   - ld_issue ld_rd=9 → next cycle busy1=1 (rs1=9), pending_count=1;
   - we_b rd_b=9 wd_b=0xAB → next cycle busy1=0, count=0, readData1=0xAB;
   - ld_issue ld_rd=0 → count stays 0.
5. Set/clear race: with reg 4 busy, ld_issue ld_rd=4 and we_b rd_b=4 in the same cycle → busy stays 1, count unchanged, data stored.
6. Reset mid-operation: 3 loads outstanding (count=3) plus registers written → assert reset → all reads 0, busy 0, count 0. A subsequent we_b to a formerly busy reg leaves count at 0.
